barrel_shift_left_logical_pipe: RTL
===================================

Name: barrel_shift_left_logical_pipe

Overview:
- Two-stage pipelined logical-left shifter implementing ARM LSL shifter-operand semantics, including carry-out, for register-specified shift amounts of 0..255.
- Sits between operand fetch and the ALU, alongside the combinational right-shift units.
- Uses a valid/ready handshake on both sides so the execute stage can stall it.
- Carries an opaque tag so results can be matched to their issuing instruction.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operation present.
- in_ready  output  1  block accepts an input this cycle.
- in_data  input  32  value to shift.
- in_amount  input  8  shift amount (Rs[7:0] semantics).
- in_carry  input  1  current C flag.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  shifted result.
- out_carry  output  1  shifter carry-out.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n); all state is clocked on the rising edge of clk.
- Reset: both stage valid flags are 0, so out_valid=0. out_data=0, out_carry=0, out_tag=0. in_ready=1 while rst_n is high after reset.
- A transfer occurs on a clock edge where valid and ready are both 1, on either side.
- Result function, with n = in_amount:
  - n=0: data unchanged; carry = in_carry.
  - 1<=n<=31: data = in_data<<n, zero-filled; carry = in_data[32-n].
  - n=32: data = 0; carry = in_data[0].
  - n>32: data = 0; carry = 0.
- Stage 1, registered on input accept:
  - Decode range class: zero, normal, thirty-two, or over.
  - Shift by n[2:0] (0..7) through three mux levels (2^0, 2^1, 2^2).
  - Compute the carry candidate from the unshifted data: in_data[32-n] for the normal class, in_data[0] for thirty-two, in_carry for zero, 0 for over.
  - Capture n[4:3], the class, and the tag.
- Stage 2, registered: shift by n[4:3]*8 through two mux levels (2^3, 2^4). Force data to 0 for the thirty-two and over classes. Register data, carry, and tag to the outputs.
- Latency: exactly 2 cycles from input accept to out_valid when out_ready is held at 1. Throughput is 1 operation per cycle.
- Flow control (elastic pipeline, no bubbles required):
  - Stage 2 loads when it is empty or when out_ready=1.
  - Stage 1 loads when it is empty or when stage 2 loads.
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready, with no combinational path from in_valid to in_ready.
- Stall: while out_valid=1 and out_ready=0, out_data, out_carry, and out_tag hold stable. A full pipeline holds 2 entries and in_ready drops to 0.
- Simultaneous input accept and output drain with a full pipeline: both stages advance in the same cycle. No operation is lost or duplicated.
- in_amount bits [7:5] are used only in range classification. For example, n=0x40 is the over class, not a shift of 0.
- Reset asserted mid-operation: both valid flags clear immediately (asynchronously), and in-flight operations are discarded. The output data/carry/tag registers clear to 0.
- out_data, out_carry, and out_tag are don't-care when out_valid=0, but must not change while a valid result is stalled.

Test Plan:
- Reset, then in_data=0x8000_0001, n=1, in_carry=0, tag=3, out_ready=1 -> 2 cycles later out_valid=1, out_data=0x0000_0002, out_carry=1, out_tag=3.
- n=0, in_data=0x1234_5678, in_carry=1 -> out_data=0x1234_5678, out_carry=1. Repeat with in_carry=0 -> out_carry=0.
- n=32, in_data=0x0000_0001 -> out_data=0, out_carry=1. n=33 -> out_data=0, out_carry=0. n=0xFF -> out_data=0, out_carry=0. n=0x40 -> out_data=0, out_carry=0.
- n=31, in_data=0x0000_0003 -> out_data=0x8000_0000, out_carry=1. n=13, in_data=0xFFFF_FFFF -> out_data=0xFFFF_E000, out_carry=1.
- Back-to-back stream of 8 ops with tags 0..7 while out_ready is toggled 1,0,0,1,... -> results emerge in order with correct values. in_ready=0 only when 2 entries are held and out_ready=0. Outputs stay stable during stalls.
- Pipeline full (2 entries), rst_n pulsed low for half a cycle -> out_valid=0 immediately, in_ready=1 after release, and the next op completes normally with no stale outputs.

Source files
------------

// File: rtl/barrel_shift_left_logical_pipe.sv
// Two-stage elastic LSL shifter with ARM shifter-operand carry-out.
// Stage 1 classifies the amount and shifts by 0..7; stage 2 shifts by 0/8/16/24 and registers the result.
module barrel_shift_left_logical_pipe #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [7:0]       in_amount,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 8;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_32     = 2'd2,
        CLS_OVER   = 2'd3
    } shift_class_e;

    // Stage 1 registers
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [1:0]        s1_amt_hi;
    shift_class_e      s1_class;
    logic              s1_carry;
    logic [TAG_W-1:0]  s1_tag;

    // Flow control
    logic s2_load_c;
    logic s1_load_c;
    logic in_fire_c;

    assign s2_load_c = !out_valid || out_ready;
    assign s1_load_c = !s1_valid || s2_load_c;
    assign in_ready  = s1_load_c;
    assign in_fire_c = in_valid && s1_load_c;

    // Stage 1 combinational: range class, carry candidate, fine shift
    shift_class_e      cls_c;
    logic              carry_c;
    logic [4:0]        carry_idx_c;
    logic [DATA_W-1:0] sh0_c;
    logic [DATA_W-1:0] sh1_c;
    logic [DATA_W-1:0] sh2_c;

    always_comb begin
        cls_c       = CLS_NORMAL;
        carry_c     = 1'b0;
        carry_idx_c = 5'(6'd32 - {1'b0, in_amount[4:0]});
        if (in_amount == AMT_W'(0)) begin
            cls_c = CLS_ZERO;
        end else if (in_amount == AMT_W'(32)) begin
            cls_c = CLS_32;
        end else if (in_amount[7:5] != 3'b000) begin
            cls_c = CLS_OVER;
        end
        case (cls_c)
            CLS_ZERO:   carry_c = in_carry;
            CLS_NORMAL: carry_c = in_data[carry_idx_c];
            CLS_32:     carry_c = in_data[0];
            default:    carry_c = 1'b0;
        endcase
    end

    always_comb begin
        sh0_c = in_amount[0] ? {in_data[DATA_W-2:0], 1'b0} : in_data;
        sh1_c = in_amount[1] ? {sh0_c[DATA_W-3:0], 2'b00} : sh0_c;
        sh2_c = in_amount[2] ? {sh1_c[DATA_W-5:0], 4'h0} : sh1_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_amt_hi <= 2'b00;
            s1_class  <= CLS_ZERO;
            s1_carry  <= 1'b0;
            s1_tag    <= '0;
        end else begin
            if (s1_load_c) begin
                s1_valid <= in_valid;
            end
            if (in_fire_c) begin
                s1_data   <= sh2_c;
                s1_amt_hi <= in_amount[4:3];
                s1_class  <= cls_c;
                s1_carry  <= carry_c;
                s1_tag    <= in_tag;
            end
        end
    end

    // Stage 2 combinational: coarse shift and range forcing
    logic [DATA_W-1:0] sh3_c;
    logic [DATA_W-1:0] sh4_c;
    logic [DATA_W-1:0] res_c;

    always_comb begin
        sh3_c = s1_amt_hi[0] ? {s1_data[DATA_W-9:0], 8'h00} : s1_data;
        sh4_c = s1_amt_hi[1] ? {sh3_c[DATA_W-17:0], 16'h0000} : sh3_c;
        res_c = sh4_c;
        if (s1_class == CLS_32 || s1_class == CLS_OVER) begin
            res_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_tag   <= '0;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= res_c;
                out_carry <= s1_carry;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule
